// File: rtl/score_hex_display_pkg.sv
// Shared encodings for the score display: game states, converter FSM states,
// active-low seven-segment glyphs and small helpers.
package score_hex_display_pkg;

  localparam int BCD_W = 20;

  typedef enum logic [2:0] {
    S_RUNNING   = 3'd0,
    S_GAME_OVER = 3'd1,
    S_WIN       = 3'd2
  } game_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_O = 7'b0100011;
  localparam logic [6:0] SEG_N = 7'b0101011;
  localparam logic [6:0] SEG_E = 7'b0000110;

  // Unknown codes fall back to RUNNING so a glitchy game FSM never blanks the score.
  function automatic game_state_e decode_state(input logic [2:0] code);
    case (code)
      3'd1:    return S_GAME_OVER;
      3'd2:    return S_WIN;
      default: return S_RUNNING;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
    return res;
  endfunction

  function automatic logic [6:0] win_glyph(input int idx);
    case (idx)
      3:       return SEG_D;
      2:       return SEG_O;
      1:       return SEG_N;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/score_hex_display_if.sv
// Status-register read port from the game FSM plus the HEX3..HEX0 display outputs.
interface score_hex_display_if
  import score_hex_display_pkg::*;
#(
  parameter int SCORE_W = 16
) ();

  // game_tick is a one-clock strobe with no back-pressure: score/game_state are
  // sampled on it; busy high means a new score sampled now is deferred, not lost.
  logic               game_tick;
  logic [SCORE_W-1:0] score;
  logic [2:0]         game_state;
  logic [1:0]         level;
  logic [6:0]         hex0;
  logic [6:0]         hex1;
  logic [6:0]         hex2;
  logic [6:0]         hex3;
  logic               busy;
  logic               overflow;
  conv_state_e        dbg_state;

  modport master (
    output game_tick, score, game_state, level,
    input  hex0, hex1, hex2, hex3, busy, overflow, dbg_state
  );

  modport slave (
    input  game_tick, score, game_state, level,
    output hex0, hex1, hex2, hex3, busy, overflow, dbg_state
  );

endinterface

// File: rtl/score_hex_display_seg7_encoder.sv
// BCD nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_encoder
  import score_hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_hex_display.sv
// Score readout: sequential double-dabble binary->BCD, double-buffered digits,
// blink on game over and "donE" on win, all outputs registered.
module score_hex_display
  import score_hex_display_pkg::*;
#(
  parameter int SCORE_W     = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int BLINK_TICKS = 30
) (
  input logic                clk,
  input logic                rst,
  score_hex_display_if.slave bus
);

  localparam int ITER_W  = $clog2(SCORE_W + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int BUF_W   = 4 * NUM_DIGITS;

  conv_state_e              state_q, state_d;
  logic [SCORE_W-1:0]       shadow_q, bin_q;
  logic [BCD_W-1:0]         bcd_q, bcd_adj;
  logic [ITER_W-1:0]        iter_q;
  logic [BUF_W-1:0]         buf_q;
  logic                     ovf_q, busy_q;
  game_state_e              gs_q, gs_in;
  logic [BLINK_W-1:0]       blink_cnt;
  logic                     blink_on;
  logic [3:0]               nib  [NUM_DIGITS];
  logic [6:0]               seg  [NUM_DIGITS];
  logic [6:0]               disp [NUM_DIGITS];
  logic [6:0]               hex_q[NUM_DIGITS];
  logic                     higher_zero;
  logic                     sample;
  logic                     unused_level;

  assign unused_level = ^bus.level;
  assign sample  = bus.game_tick && (bus.score != shadow_q);
  assign bcd_adj = bcd_add3(bcd_q);
  assign gs_in   = decode_state(bus.game_state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sample) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SHIFT;
      ST_SHIFT:  if (iter_q == ITER_W'(SCORE_W - 1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      buf_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (sample) begin
          bin_q    <= bus.score;
          shadow_q <= bus.score;
        end
        ST_LOAD: begin
          bcd_q  <= '0;
          iter_q <= '0;
          busy_q <= 1'b1;
        end
        ST_SHIFT: begin
          bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
          bin_q  <= {bin_q[SCORE_W-2:0], 1'b0};
          iter_q <= iter_q + 1'b1;
        end
        ST_COMMIT: begin
          buf_q  <= bcd_q[BUF_W-1:0];
          ovf_q  <= |bcd_q[BCD_W-1:BUF_W];
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Blink phase restarts whenever GAME_OVER is (re)entered, so digits always show first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs_q      <= S_RUNNING;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (bus.game_tick) begin
      gs_q <= gs_in;
      if (gs_in == S_GAME_OVER && gs_q == S_GAME_OVER) begin
        if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encoder u_enc (
      .nibble (nib[g]),
      .seg    (seg[g])
    );
  end

  always_comb begin
    higher_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) nib[i] = ovf_q ? 4'd9 : buf_q[4*i +: 4];
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (nib[i] == 4'd0);
      disp[i]     = (higher_zero && i != 0) ? SEG_BLANK : seg[i];
      if (gs_q == S_WIN)                        disp[i] = win_glyph(i);
      else if (gs_q == S_GAME_OVER && !blink_on) disp[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= disp[i];
    end
  end

  assign bus.hex0      = hex_q[0];
  assign bus.hex1      = hex_q[1];
  assign bus.hex2      = hex_q[2];
  assign bus.hex3      = hex_q[3];
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.dbg_state = state_q;

endmodule
